mem_bridge: RTL

//  Memory-side stage directly downstream of the cache control unit. Accepts whole-block

---
 rtl/mem_bridge_pkg.sv | 22 ++
 rtl/mem_wb_buffer.sv | 41 ++++
 rtl/mem_bridge.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the memory bridge: default widths and the
// bus-side state encoding used by mem_bridge.
package mem_bridge_pkg;

    localparam int PA_WIDTH_DEF  = 32;
    localparam int WRD_WIDTH_DEF = 32;
    localparam int BLK_WIDTH_DEF = 128;

    // Bus-side sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } bus_state_t;

    // Number of bus beats in one cache block.
    function automatic int beats_of(input int blk_width, input int wrd_width);
        return blk_width / wrd_width;
    endfunction

endpackage

// File: rtl/mem_wb_buffer.sv
// One-entry write-back buffer: holds an aligned block address plus block
// data, and compares a probe address against the held entry.
// Used by mem_bridge only when WB_BUFFER_EN is defined.
module mem_wb_buffer #(
    parameter int PA_WIDTH  = 32,
    parameter int BLK_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [PA_WIDTH-1:0]  load_addr,
    input  logic [BLK_WIDTH-1:0] load_blk,
    input  logic                 take,
    input  logic [PA_WIDTH-1:0]  cmp_addr,
    output logic                 valid,
    output logic [PA_WIDTH-1:0]  addr,
    output logic [BLK_WIDTH-1:0] blk,
    output logic                 hit
);

    // Entry storage: load fills an empty entry, take empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            blk   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            blk   <= load_blk;
        end else if (take) begin
            valid <= 1'b0;
        end
    end

    // Address match against the held entry (probe is already aligned).
    always_comb begin
        hit = valid && (addr == cmp_addr);
    end

endmodule

// File: rtl/mem_bridge.sv
// Memory bridge: serialises cache write-back and fill blocks into
// WRD_WIDTH beats on a req/ack memory bus and assembles fill blocks.
// Optional feature macro: WB_BUFFER_EN (one-entry write-back buffer).
//
// Handshake: a requester raises *_valid and holds address/data stable;
// the transfer happens on the rising edge where *_valid and *_ready are
// both high. On the memory side bus_req/bus_we/bus_addr/bus_wdata stay
// stable until the edge that samples bus_ack=1.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int PA_WIDTH  = PA_WIDTH_DEF,
    parameter int WRD_WIDTH = WRD_WIDTH_DEF,
    parameter int BLK_WIDTH = BLK_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [PA_WIDTH-1:0]  wb_addr,
    input  logic [BLK_WIDTH-1:0] wb_blk,
    input  logic                 fill_valid,
    output logic                 fill_ready,
    input  logic [PA_WIDTH-1:0]  fill_addr,
    output logic                 fill_done,
    output logic [BLK_WIDTH-1:0] fill_blk,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [PA_WIDTH-1:0]  bus_addr,
    output logic [WRD_WIDTH-1:0] bus_wdata,
    input  logic                 bus_ack,
    input  logic [WRD_WIDTH-1:0] bus_rdata,
    output logic                 busy,
    output bus_state_t           dbg_state
);

    localparam int BEATS      = beats_of(BLK_WIDTH, WRD_WIDTH);
    localparam int BEAT_BYTES = WRD_WIDTH / 8;
    localparam int OFF_BITS   = $clog2(BLK_WIDTH / 8);
    localparam int CW         = $clog2(BEATS);
    localparam logic [PA_WIDTH-1:0] OFF_MASK = PA_WIDTH'((1 << OFF_BITS) - 1);
    localparam logic [CW-1:0]       LAST_BEAT = CW'(BEATS - 1);

    bus_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [PA_WIDTH-1:0]  addr_q, addr_d;
    logic [WRD_WIDTH-1:0] wdata_q, wdata_d;
    logic                 done_q, done_d;
    logic [BLK_WIDTH-1:0] blk_q, blk_d;
    logic [BLK_WIDTH-1:0] asm_q, asm_d;
    logic [BLK_WIDTH-1:0] fblk_q, fblk_d;
    logic                 rdy_q;
    logic                 idle;
    logic [PA_WIDTH-1:0]  wb_base;
    logic [PA_WIDTH-1:0]  fill_base;

`ifdef WB_BUFFER_EN
    logic                 buf_valid;
    logic [PA_WIDTH-1:0]  buf_addr;
    logic [BLK_WIDTH-1:0] buf_blk;
    logic                 buf_hit;
    logic                 buf_load;
    logic                 buf_take;

    mem_wb_buffer #(
        .PA_WIDTH  (PA_WIDTH),
        .BLK_WIDTH (BLK_WIDTH)
    ) u_wb_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .load_addr (wb_base),
        .load_blk  (wb_blk),
        .take      (buf_take),
        .cmp_addr  (fill_base),
        .valid     (buf_valid),
        .addr      (buf_addr),
        .blk       (buf_blk),
        .hit       (buf_hit)
    );
`endif

    // Ready decode; rdy_q keeps both readies low while reset is applied.
    always_comb begin
        idle      = (state_q == ST_IDLE);
        wb_base   = wb_addr & ~OFF_MASK;
        fill_base = fill_addr & ~OFF_MASK;
`ifdef WB_BUFFER_EN
        wb_ready   = rdy_q && !buf_valid;
        fill_ready = rdy_q && idle;
        buf_load   = wb_valid && wb_ready;
`else
        wb_ready   = rdy_q && idle;
        fill_ready = rdy_q && idle && !wb_valid;
`endif
    end

    // Next-state and next bus/datapath values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        blk_d   = blk_q;
        asm_d   = asm_q;
        fblk_d  = fblk_q;
`ifdef WB_BUFFER_EN
        buf_take = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef WB_BUFFER_EN
                // A pending fill beats the buffer drain; a buffer hit skips the bus.
                if (fill_valid && fill_ready) begin
                    if (buf_hit) begin
                        state_d = ST_DONE;
                        fblk_d  = buf_blk;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = fill_base;
                        wdata_d = '0;
                    end
                end else if (buf_valid) begin
                    buf_take = 1'b1;
                    state_d  = ST_WB;
                    req_d    = 1'b1;
                    we_d     = 1'b1;
                    addr_d   = buf_addr;
                    wdata_d  = buf_blk[WRD_WIDTH-1:0];
                    blk_d    = buf_blk;
                end
`else
                // Write-back first so a later fill sees the evicted data in memory.
                if (wb_valid && wb_ready) begin
                    state_d = ST_WB;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = wb_base;
                    wdata_d = wb_blk[WRD_WIDTH-1:0];
                    blk_d   = wb_blk;
                end else if (fill_valid && fill_ready) begin
                    state_d = ST_FILL;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = fill_base;
                    wdata_d = '0;
                end
`endif
            end
            ST_WB, ST_FILL: begin
                if (bus_ack) begin
                    if (state_q == ST_FILL) begin
                        asm_d[cnt_q*WRD_WIDTH +: WRD_WIDTH] = bus_rdata;
                    end
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        addr_d  = '0;
                        wdata_d = '0;
                        if (state_q == ST_FILL) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            fblk_d  = asm_d;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        addr_d  = addr_q + PA_WIDTH'(BEAT_BYTES);
                        wdata_d = blk_q[cnt_d*WRD_WIDTH +: WRD_WIDTH];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered bus outputs, block holding and fill assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            blk_q   <= '0;
            asm_q   <= '0;
            fblk_q  <= '0;
        end else begin
            rdy_q   <= 1'b1;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            blk_q   <= blk_d;
            asm_q   <= asm_d;
            fblk_q  <= fblk_d;
        end
    end

    // Output mapping.
    always_comb begin
        bus_req   = req_q;
        bus_we    = we_q;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        fill_done = done_q;
        fill_blk  = fblk_q;
        busy      = (state_q != ST_IDLE);
        dbg_state = state_q;
    end

endmodule
